// File: rtl/mux_nt1_arb_nb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_nt1_arb_nb_pkg : shared mode encodings and width helper for the N:1 mux
// Revision: 1.0
// ---------------------------------------------------------------------------
package mux_nt1_arb_nb_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nt1_arb_nb_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick_nb : combinational round-robin pick, first set bit after LAST (mod N)
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_pick_nb
  import mux_nt1_arb_nb_pkg::*;
#(
  parameter  int N    = 6,
  localparam int SELW = clog2(N)
) (
  input  logic [N-1:0]    REQ,
  input  logic [SELW-1:0] LAST,
  output logic            GNT_VLD,
  output logic [SELW-1:0] GNT_IDX
);

  // Scanning offsets from farthest to nearest lets the nearest hit win,
  // which is the rotate / priority-encode / unrotate result.
  always_comb begin
    int idx;
    idx     = 0;
    GNT_VLD = 1'b0;
    GNT_IDX = '0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(LAST) + i) % N;
      if (REQ[idx]) begin
        GNT_VLD = 1'b1;
        GNT_IDX = SELW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_nt1_arb_nb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_nt1_arb_nb : N:1 valid/ready mux (explicit select or round-robin) with
//                  a one-entry registered output stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mux_nt1_arb_nb
  import mux_nt1_arb_nb_pkg::*;
#(
  parameter  int N    = 6,
  parameter  int W    = 32,
  localparam int SELW = clog2(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            MODE,
  input  logic [SELW-1:0] SEL,
  input  logic [N-1:0]    REQ_VALID,
  input  logic [N*W-1:0]  REQ_DATA,
  output logic [N-1:0]    REQ_READY,
  output logic            OUT_VALID,
  output logic [W-1:0]    OUT_DATA,
  output logic [SELW-1:0] OUT_CH,
  input  logic            OUT_READY
);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_ch_q,    out_ch_d;
  logic [SELW-1:0] last_q,      last_d;

  logic            rr_vld;
  logic [SELW-1:0] rr_idx;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;
  logic [W-1:0]    gnt_data;
  logic            load;
  logic            xfer;

  rr_pick_nb #(.N(N)) u_rr_pick (
    .REQ     (REQ_VALID),
    .LAST    (last_q),
    .GNT_VLD (rr_vld),
    .GNT_IDX (rr_idx)
  );

  always_comb begin
    gnt_vld     = 1'b0;
    gnt_idx     = '0;
    gnt_data    = '0;
    REQ_READY   = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;

    if (MODE == MODE_RR) begin
      gnt_vld = rr_vld;
      gnt_idx = rr_idx;
    end else begin
      // Out-of-range SEL matches no channel, so it never grants.
      for (int k = 0; k < N; k++) begin
        if (SEL == SELW'(k) && REQ_VALID[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(k);
        end
      end
    end

    load = !out_valid_q || OUT_READY;
    xfer = gnt_vld && load;

    for (int k = 0; k < N; k++) begin
      if (gnt_idx == SELW'(k)) begin
        gnt_data     = REQ_DATA[k*W +: W];
        REQ_READY[k] = xfer;
      end
    end

    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      last_d      = gnt_idx;
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= SELW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_CH    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_nt1_arb_nb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux_nt1_arb_nb : directed stimulus with a queue scoreboard for the N:1 mux
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mux_nt1_arb_nb;

  localparam int N    = 6;
  localparam int W    = 32;
  localparam int SELW = 3;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            MODE = 1'b0;
  logic [SELW-1:0] SEL = '0;
  logic [N-1:0]    REQ_VALID = '0;
  logic [N*W-1:0]  REQ_DATA = '0;
  logic [N-1:0]    REQ_READY;
  logic            OUT_VALID;
  logic [W-1:0]    OUT_DATA;
  logic [SELW-1:0] OUT_CH;
  logic            OUT_READY = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] epoch = 8'h00;
  logic [SELW+W-1:0] sb[$];

  mux_nt1_arb_nb #(.N(N), .W(W)) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .SEL(SEL),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_CH(OUT_CH),
    .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] data_of(input logic [7:0] ep, input int k);
    return {16'hDEAD, ep, 8'(k)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_epoch(input logic [7:0] ep);
    epoch = ep;
    for (int k = 0; k < N; k++) REQ_DATA[k*W +: W] = data_of(ep, k);
  endtask

  // Check the accept strobe mid-cycle; an expected transfer goes to the scoreboard.
  task automatic tick(input logic [N-1:0] exp_rdy, input int exp_ch);
    @(negedge CLK);
    chk("req_ready", 64'(REQ_READY), 64'(exp_rdy));
    if (exp_rdy != '0) sb.push_back({SELW'(exp_ch), data_of(epoch, exp_ch)});
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every consumed output item must match the scoreboard head.
  always @(negedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY) begin
      if (sb.size() == 0) begin
        chk("unexpected_item", 64'({OUT_CH, OUT_DATA}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [SELW+W-1:0] e;
        e = sb.pop_front();
        chk("out_ch", 64'(OUT_CH), 64'(e[SELW+W-1:W]));
        chk("out_data", 64'(OUT_DATA), 64'(e[W-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_epoch(8'h00);
    #2;
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_out_data", 64'(OUT_DATA), 64'd0);
    chk("rst_out_ch", 64'(OUT_CH), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Load an item, hold it, then reset asynchronously mid-cycle.
    MODE = 1'b0; SEL = 3'd4; REQ_VALID = 6'b010000; OUT_READY = 1'b0;
    tick(6'b010000, 4);
    REQ_VALID = '0;
    @(negedge CLK);
    chk("held_valid", 64'(OUT_VALID), 64'd1);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_valid", 64'(OUT_VALID), 64'd0);
    chk("async_rst_data", 64'(OUT_DATA), 64'd0);
    chk("async_rst_ch", 64'(OUT_CH), 64'd0);
    sb.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    OUT_READY = 1'b1;
    tick(6'b000000, 0);

    // Explicit select, then out-of-range SEL values.
    set_epoch(8'h01);
    SEL = 3'd3; REQ_VALID = 6'b111111;
    tick(6'b001000, 3);
    SEL = 3'd6;
    tick(6'b000000, 0);
    SEL = 3'd7;
    @(negedge CLK);
    chk("sel7_drained", 64'(OUT_VALID), 64'd0);
    tick(6'b000000, 0);

    // Round-robin fairness starting from LAST=5.
    set_epoch(8'h02);
    SEL = 3'd5;
    tick(6'b100000, 5);
    MODE = 1'b1;
    for (int i = 0; i < 12; i++) tick(6'(1 << (i % N)), i % N);

    // Backpressure with channel 2 held.
    REQ_VALID = '0;
    tick(6'b000000, 0);
    set_epoch(8'h03);
    MODE = 1'b0; SEL = 3'd2; REQ_VALID = 6'b111111;
    tick(6'b000100, 2);
    OUT_READY = 1'b0; MODE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("stall_ch", 64'(OUT_CH), 64'd2);
      chk("stall_data", 64'(OUT_DATA), 64'(data_of(8'h03, 2)));
      tick(6'b000000, 0);
    end
    OUT_READY = 1'b1;
    tick(6'b001000, 3);
    REQ_VALID = '0;
    tick(6'b000000, 0);

    // Sparse requesters with pointer wrap, then a single requester.
    set_epoch(8'h04);
    MODE = 1'b0; SEL = 3'd4; REQ_VALID = 6'b010000;
    tick(6'b010000, 4);
    MODE = 1'b1; REQ_VALID = 6'b000011;
    tick(6'b000001, 0);
    tick(6'b000010, 1);
    tick(6'b000001, 0);
    REQ_VALID = 6'b100000;
    for (int i = 0; i < 3; i++) tick(6'b100000, 5);

    // Mode switch continues from the explicit-select grant.
    set_epoch(8'h05);
    MODE = 1'b0; SEL = 3'd1; REQ_VALID = 6'b111111;
    tick(6'b000010, 1);
    MODE = 1'b1;
    for (int i = 0; i < 6; i++) tick(6'(1 << ((i + 2) % N)), (i + 2) % N);

    REQ_VALID = '0;
    tick(6'b000000, 0);
    tick(6'b000000, 0);
    chk("final_out_valid", 64'(OUT_VALID), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
